// File: rtl/ex_op_sched.sv
// Execute-stage scheduler: issues decoded ops to ALU/memory/branch units and holds
// the pipeline for multi-cycle multiply/divide. Optional stall counter: EX_SCHED_STALL_CNT_EN.
module ex_op_sched #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_valid,
    input  logic [1:0]  in_fc2,
    input  logic [3:0]  in_fc4,
    input  logic        in_flush,
    output logic        out_ready,
    output logic        out_stall,
    output logic        out_alu_en,
    output logic        out_mem_en,
    output logic        out_br_en,
    output logic [3:0]  out_op,
    output logic [1:0]  out_cls,
    output logic        out_done,
    output logic        out_illegal,
    output logic [15:0] out_stall_cnt
);

    // state | meaning
    // IDLE  | ready to accept; single-cycle ops complete in the following cycle
    // BUSY  | multiply/divide in flight; counter runs down to completion
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alu_en_q, alu_en_d;
    logic             mem_en_q, mem_en_d;
    logic             br_en_q, br_en_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       cls_q, cls_d;
    logic             legal;
    logic             is_mul;
    logic             is_div;

    function automatic logic code_legal(input logic [1:0] cls, input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (cls)
            2'b00:   ok = (op <= 4'd5) || ((op >= 4'd8) && (op <= 4'd11));
            2'b01:   ok = (op <= 4'd1);
            2'b10:   ok = (op <= 4'd2);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign legal  = code_legal(in_fc2, in_fc4);
    assign is_mul = (in_fc2 == 2'b00) && (in_fc4 == 4'b0100);
    assign is_div = (in_fc2 == 2'b00) && (in_fc4 == 4'b0101);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_en_d  = 1'b0;
        mem_en_d  = 1'b0;
        br_en_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        op_d      = op_q;
        cls_d     = cls_q;
        // Flush dominates everything, including a completion on the same edge.
        if (in_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d  = in_fc4;
                        cls_d = in_fc2;
                        if (!legal) begin
                            illegal_d = 1'b1;
                        end else if (is_mul || is_div) begin
                            alu_en_d = 1'b1;
                            state_d  = BUSY;
                            cnt_d    = is_div ? DIV_LOAD : MUL_LOAD;
                        end else begin
                            done_d = 1'b1;
                            case (in_fc2)
                                2'b00:   alu_en_d = 1'b1;
                                2'b01:   mem_en_d = 1'b1;
                                default: br_en_d  = 1'b1;
                            endcase
                        end
                    end
                end
                BUSY: begin
                    alu_en_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            alu_en_q  <= 1'b0;
            mem_en_q  <= 1'b0;
            br_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= 4'h0;
            cls_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_en_q  <= alu_en_d;
            mem_en_q  <= mem_en_d;
            br_en_q   <= br_en_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            op_q      <= op_d;
            cls_q     <= cls_d;
        end
    end

    assign out_ready   = (state_q == IDLE);
    assign out_stall   = (state_q == BUSY);
    assign out_alu_en  = alu_en_q;
    assign out_mem_en  = mem_en_q;
    assign out_br_en   = br_en_q;
    assign out_done    = done_q;
    assign out_illegal = illegal_q;
    assign out_op      = op_q;
    assign out_cls     = cls_q;

`ifdef EX_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == BUSY) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_stall_cnt = stall_cnt_q;
`else
    assign out_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_op_sched.sv
// Directed bench for ex_op_sched: vector table for single-cycle/illegal ops plus
// hand sequences for multiply, divide flush, flush-at-completion and async reset.
module tb_ex_op_sched;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_fc2 = 2'b00;
    logic [3:0]  in_fc4 = 4'h0;
    logic        in_flush = 1'b0;
    logic        out_ready, out_stall, out_alu_en, out_mem_en, out_br_en;
    logic [3:0]  out_op;
    logic [1:0]  out_cls;
    logic        out_done, out_illegal;
    logic [15:0] out_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ex_op_sched dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_fc2(in_fc2),
        .in_fc4(in_fc4), .in_flush(in_flush), .out_ready(out_ready),
        .out_stall(out_stall), .out_alu_en(out_alu_en), .out_mem_en(out_mem_en),
        .out_br_en(out_br_en), .out_op(out_op), .out_cls(out_cls),
        .out_done(out_done), .out_illegal(out_illegal), .out_stall_cnt(out_stall_cnt)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic       valid;
        logic [1:0] fc2;
        logic [3:0] fc4;
        logic       flush;
        logic       done;
        logic       illegal;
        logic       alu;
        logic       mem;
        logic       br;
        logic [3:0] op;
        logic [1:0] cls;
    } vec_t;

    vec_t vecs[11];

`ifdef EX_SCHED_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [3:0] o, input logic f);
        in_valid = v;
        in_fc2   = c;
        in_fc4   = o;
        in_flush = f;
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [3:0] o,
                                input logic f, input logic d, input logic il, input logic a,
                                input logic m, input logic b, input logic [3:0] eo,
                                input logic [1:0] ec);
        vec_t r;
        r.valid = v; r.fc2 = c; r.fc4 = o; r.flush = f; r.done = d; r.illegal = il;
        r.alu = a; r.mem = m; r.br = b; r.op = eo; r.cls = ec;
        return r;
    endfunction

    logic [15:0] exp_sc;

    initial begin
        //          v  fc2    fc4     fl  dn il al me br  op      cls
        vecs[0]  = mk(1, 2'b00, 4'b0000, 0, 1, 0, 1, 0, 0, 4'b0000, 2'b00);
        vecs[1]  = mk(1, 2'b01, 4'b0000, 0, 1, 0, 0, 1, 0, 4'b0000, 2'b01);
        vecs[2]  = mk(1, 2'b10, 4'b0010, 0, 1, 0, 0, 0, 1, 4'b0010, 2'b10);
        vecs[3]  = mk(1, 2'b00, 4'b0110, 0, 0, 1, 0, 0, 0, 4'b0110, 2'b00);
        vecs[4]  = mk(1, 2'b11, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000, 2'b11);
        vecs[5]  = mk(1, 2'b01, 4'b0010, 0, 0, 1, 0, 0, 0, 4'b0010, 2'b01);
        vecs[6]  = mk(1, 2'b00, 4'b1011, 0, 1, 0, 1, 0, 0, 4'b1011, 2'b00);
        vecs[7]  = mk(1, 2'b10, 4'b0011, 0, 0, 1, 0, 0, 0, 4'b0011, 2'b10);
        vecs[8]  = mk(1, 2'b00, 4'b0011, 1, 0, 0, 0, 0, 0, 4'b0011, 2'b10);
        vecs[9]  = mk(0, 2'b00, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0011, 2'b10);
        vecs[10] = mk(1, 2'b01, 4'b0001, 0, 1, 0, 0, 1, 0, 4'b0001, 2'b01);

        // Reset
        repeat (3) step();
        in_rst = 1'b0;
        #1;
        chk("rst_ready", out_ready, 1);
        chk("rst_stall", out_stall, 0);
        chk("rst_done", out_done, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_en", {out_alu_en, out_mem_en, out_br_en}, 0);
        chk("rst_op", {out_cls, out_op}, 0);
        chk("rst_stall_cnt", out_stall_cnt, 0);

        // Single-cycle and illegal vectors, one per edge
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].fc2, vecs[i].fc4, vecs[i].flush);
            step();
            chk($sformatf("v%0d_done", i), out_done, vecs[i].done);
            chk($sformatf("v%0d_illegal", i), out_illegal, vecs[i].illegal);
            chk($sformatf("v%0d_en", i), {out_alu_en, out_mem_en, out_br_en},
                {vecs[i].alu, vecs[i].mem, vecs[i].br});
            chk($sformatf("v%0d_op", i), out_op, vecs[i].op);
            chk($sformatf("v%0d_cls", i), out_cls, vecs[i].cls);
            chk($sformatf("v%0d_ready", i), out_ready, 1);
        end
        drive(0, 2'b00, 4'h0, 0);
        step();

        // Multiply: an add held on the inputs during the stall waits for ready
        drive(1, 2'b00, 4'b0100, 0);
        step();
        drive(1, 2'b00, 4'b0000, 0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("mul_stall_c%0d", k), out_stall, 1);
            chk($sformatf("mul_ready_c%0d", k), out_ready, 0);
            chk($sformatf("mul_done_c%0d", k), out_done, 0);
            chk($sformatf("mul_alu_c%0d", k), out_alu_en, 1);
            chk($sformatf("mul_op_c%0d", k), out_op, 4'b0100);
            step();
        end
        chk("mul_done", out_done, 1);
        chk("mul_done_ready", out_ready, 1);
        chk("mul_done_stall", out_stall, 0);
        chk("mul_done_op", out_op, 4'b0100);
        exp_sc = CNT_ON ? 16'd3 : 16'd0;
        chk("mul_stall_cnt", out_stall_cnt, exp_sc);
        step();
        drive(0, 2'b00, 4'h0, 0);
        chk("post_mul_add_done", out_done, 1);
        chk("post_mul_add_op", out_op, 4'b0000);
        chk("post_mul_add_alu", out_alu_en, 1);
        step();

        // Divide flushed in its 3rd busy cycle
        drive(1, 2'b00, 4'b0101, 0);
        step();
        drive(0, 2'b00, 4'h0, 0);
        chk("div_busy1", out_stall, 1);
        step();
        chk("div_busy2", out_stall, 1);
        step();
        chk("div_busy3", out_stall, 1);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        chk("div_flush_ready", out_ready, 1);
        chk("div_flush_stall", out_stall, 0);
        chk("div_flush_alu", out_alu_en, 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("div_flush_nodone%0d", k), out_done, 0);
            step();
        end
        chk("div_flush_op", out_op, 4'b0101);
        exp_sc = CNT_ON ? 16'd6 : 16'd0;
        chk("div_stall_cnt", out_stall_cnt, exp_sc);

        // Flush on the completion edge of a multiply suppresses done
        drive(1, 2'b00, 4'b0100, 0);
        step();
        drive(0, 2'b00, 4'h0, 0);
        step();
        step();
        chk("mulf_last_busy", out_stall, 1);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        chk("mulf_nodone", out_done, 0);
        chk("mulf_ready", out_ready, 1);
        step();
        chk("mulf_nodone_late", out_done, 0);

        // Asynchronous reset two cycles into a divide
        drive(1, 2'b00, 4'b0101, 0);
        step();
        drive(0, 2'b00, 4'h0, 0);
        step();
        chk("div2_busy", out_stall, 1);
        #2;
        in_rst = 1'b1;
        #1;
        chk("arst_ready", out_ready, 1);
        chk("arst_stall", out_stall, 0);
        chk("arst_alu", out_alu_en, 0);
        chk("arst_op", {out_cls, out_op}, 0);
        chk("arst_stall_cnt", out_stall_cnt, 0);
        @(negedge in_clk);
        in_rst = 1'b0;
        drive(1, 2'b00, 4'b0000, 0);
        step();
        drive(0, 2'b00, 4'h0, 0);
        chk("arst_add_done", out_done, 1);
        chk("arst_add_alu", out_alu_en, 1);
        step();
        chk("arst_add_single", out_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_op_sched.md
Name: ex_op_sched

Overview:
- Execute-stage scheduler that sits between the ALU-control decode (class code fc2, operation code fc4) and the execute units.
- Accepts one decoded operation per handshake.
- Single-cycle ALU, memory and branch operations complete in one cycle; signed multiply and divide hold the stage for a parameterised number of cycles.
- Drives the pipeline stall, per-class unit enables, the completion pulse and the illegal-op flag.

Parameters:
- MUL_LAT, 4, cycles from accept to out_done for multiply (fc2=00, fc4=0100); legal range 2..2^CNT_W.
- DIV_LAT, 8, cycles from accept to out_done for divide (fc2=00, fc4=0101); legal range 2..2^CNT_W.
- CNT_W, 4, width of the internal latency down-counter.

Ports:
- in_clk  input  1  clock; all state on rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded operation present.
- in_fc2  input  2  operation class: 00 ALU, 01 memory, 10 branch, 11 reserved.
- in_fc4  input  4  operation code within class.
- in_flush  input  1  kill the in-flight operation (branch redirect).
- out_ready  output  1  scheduler can accept this cycle.
- out_stall  output  1  upstream pipeline must hold.
- out_alu_en  output  1  ALU enable, registered.
- out_mem_en  output  1  memory enable, registered.
- out_br_en  output  1  branch unit enable, registered.
- out_op  output  4  latched fc4 of the current/last operation.
- out_cls  output  2  latched fc2 of the current/last operation.
- out_done  output  1  one-cycle completion pulse.
- out_illegal  output  1  one-cycle pulse for an unsupported code.
- out_stall_cnt  output  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset:
  - State IDLE, counter 0.
  - out_ready=1; all other outputs 0, including out_op, out_cls and out_stall_cnt.
- Accept: rising edge where in_valid=1, out_ready=1 and in_flush=0. On accept, out_op and out_cls load in_fc4 and in_fc2.
- Legal codes:
  - fc2=00: fc4 in {0000..0101, 1000..1011}.
  - fc2=01: fc4 in {0000, 0001}.
  - fc2=10: fc4 in {0000..0010}.
  - Everything else, including fc2=11, is illegal.
- States: IDLE, BUSY.
- IDLE:
  - out_ready=1, out_stall=0.
  - Single-cycle legal op accepted at edge T: during cycle T+1, out_done=1 and exactly one of the alu/mem/br enables is 1; state stays IDLE. Back-to-back accepts give one out_done per cycle.
  - Illegal op accepted at T: out_illegal=1 in T+1; no enable and no out_done.
  - Mul/div accepted at T: out_alu_en=1; counter loads LAT-2; state goes to BUSY from T+1.
- BUSY:
  - out_ready=0, out_stall=1, out_alu_en held at 1.
  - Counter decrements each cycle.
  - At the edge where counter=0: state returns to IDLE and out_done=1 in the following cycle.
  - Net result: operation accepted at edge T has out_done high in cycle T+LAT. Multiply with default parameters: done 4 cycles after accept.
- out_ready and out_stall are combinational from state only, with no dependence on in_valid.
- Completion cycle: an op accepted in the same cycle that out_done is high is legal (ready=1 in IDLE), so back-to-back issue after a divide has no bubble.
- Flush:
  - in_flush=1 at an edge forces state IDLE and counter 0.
  - Clears the enables and suppresses out_done and out_illegal for the next cycle.
  - in_valid is ignored during that cycle.
  - out_op and out_cls keep their values.
- Flush vs completion: flush in the same cycle as BUSY with counter=0 wins; no out_done.
- Reset mid-BUSY: immediate return to reset values; no out_done.
- Parameters outside their legal range are unsupported.

Optional Feature:
- Macro: EX_SCHED_STALL_CNT_EN.
- Defined: out_stall_cnt increments on every rising edge where out_stall=1.
  - Saturates at 16'hFFFF.
  - Cleared only by in_rst; unaffected by flush.
- Undefined: no counter logic; out_stall_cnt tied to 16'h0000.

Test Plan:
- Reset check: assert in_rst, then release → out_ready=1, out_stall=0, out_done=0, out_op=0, out_stall_cnt=0.
- Single-cycle ops: accept add (00/0000), load (01/0000), beq (10/0010) on three consecutive edges → out_done high 3 consecutive cycles; enables alu, mem, br in order; out_op=0000, 0000, 0010.
- Multiply latency, default parameters: accept 00/0100 at edge T → out_stall=1 for cycles T+1..T+3; out_done in T+4; a second add presented during the stall is not accepted until ready=1; with the macro defined, out_stall_cnt=3.
- Divide with flush: accept 00/0101, assert in_flush in the 3rd BUSY cycle → IDLE next cycle; no out_done within 10 cycles; out_op stays 0101.
- Illegal codes: accept 00/0110, then 11/0000, then 01/0010 → out_illegal pulses each following cycle; out_done=0 and all enables 0.
- Asynchronous reset mid-divide: assert in_rst asynchronously (between edges) 2 cycles into BUSY → outputs return to reset values immediately; after release, an add accepted completes in 1 cycle.
